// File: rtl/max_pool_win_buf_pkg.sv
// Shared constants for the 2x2 / stride-2 max-pool window generator.
//   WIN_N            : elements per emitted window
//   WIN_TL..WIN_BR   : element slot of each window position in win_data (LSB-first)
//   POOL_K           : pooling kernel size and stride
//   pix_phase_e      : role of the incoming pixel, decoded from {row_odd, col[0]}
package max_pool_win_buf_pkg;

  localparam int WIN_N  = 4;
  localparam int WIN_TL = 0;
  localparam int WIN_TR = 1;
  localparam int WIN_BL = 2;
  localparam int WIN_BR = 3;
  localparam int POOL_K = 2;

  typedef enum logic [1:0] {
    PH_TOP_L = 2'b00,   // even row, even col
    PH_TOP_R = 2'b01,   // even row, odd col
    PH_BOT_L = 2'b10,   // odd row, even col
    PH_BOT_R = 2'b11    // odd row, odd col
  } pix_phase_e;

  // Address width of a buffer of the given depth; never below one bit.
  function automatic int lb_addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/max_pool_win_buf_line_buf.sv
// pool_line_buf: half-row store of top-row column pairs.
//   aclk    : clock
//   aclken  : clock enable, gates both ports
//   wr_en / wr_addr / wr_data : write port, wr_data = {top-right, top-left}
//   rd_en / rd_addr           : synchronous read request
//   rd_data                   : read data, 1-cycle latency, held when no read
// Contents are never reset; every entry is written in the even row before
// the odd row reads it.
module pool_line_buf
  import max_pool_win_buf_pkg::*;
#(
  parameter int data_width = 8,
  parameter int depth      = 32,
  parameter int addr_w     = 5
) (
  input  logic                         aclk,
  input  logic                         aclken,
  input  logic                         wr_en,
  input  logic [addr_w-1:0]            wr_addr,
  input  logic [POOL_K*data_width-1:0] wr_data,
  input  logic                         rd_en,
  input  logic [addr_w-1:0]            rd_addr,
  output logic [POOL_K*data_width-1:0] rd_data
);

  logic [POOL_K*data_width-1:0] mem [depth];

  always_ff @(posedge aclk) begin
    if (aclken && wr_en) mem[wr_addr] <= wr_data;
    if (aclken && rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/max_pool_win_buf.sv
// max_pool_win_buf: turns a raster pixel stream of one channel into 2x2,
// stride-2 windows for a downstream max tree.
//   aclk, areset (sync, active-high), aclken (global enable)
//   fmap_w                     : runtime width, bit 0 ignored
//   s_data/s_valid/s_last/s_ready : input pixel stream
//   win_data/win_vld/win_last/win_ready : window stream, win_data LSB-first
//                                         {BR, BL, TR, TL}
//   frame_err                  : one-cycle pulse after an off-grid s_last
// simulation_delay is kept for interface compatibility; no NBA delays are used.
module max_pool_win_buf
  import max_pool_win_buf_pkg::*;
#(
  parameter int data_width       = 8,
  parameter int max_fmap_w       = 64,
  parameter int simulation_delay = 1
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic                                aclken,
  input  logic [$clog2(max_fmap_w+1)-1:0]     fmap_w,
  input  logic [data_width-1:0]               s_data,
  input  logic                                s_valid,
  input  logic                                s_last,
  output logic                                s_ready,
  output logic [WIN_N*data_width-1:0]         win_data,
  output logic                                win_vld,
  output logic                                win_last,
  input  logic                                win_ready,
  output logic                                frame_err
);

  localparam int CW       = $clog2(max_fmap_w + 1);
  localparam int LB_DEPTH = max_fmap_w / POOL_K;
  localparam int AW       = lb_addr_w(LB_DEPTH);
  localparam int PW       = POOL_K * data_width;

  if ((max_fmap_w < 2) || ((max_fmap_w % 2) != 0) || (simulation_delay < 0)) begin : g_param_chk
    $error("max_pool_win_buf: max_fmap_w must be even and >= 2");
  end

  logic [CW-1:0]         col, w_eff, col_max;
  logic                  row_odd;
  logic                  acc, at_end, bad_end;
  pix_phase_e            phase;
  logic [data_width-1:0] top_hold, bot_hold;
  logic                  lb_wr_en, lb_rd_en, load_win;
  logic [AW-1:0]         lb_addr;
  logic [PW-1:0]         lb_rd_data;

  assign w_eff   = fmap_w & ~CW'(1);
  assign col_max = w_eff - CW'(1);
  // Any full output register blocks input, even on rows that emit nothing.
  assign s_ready = aclken & ~areset & (~win_vld | win_ready);
  assign acc     = s_valid & s_ready;
  assign phase   = pix_phase_e'({row_odd, col[0]});
  assign at_end  = (col == col_max);
  // s_last is only legal on the bottom-right pixel of the last window.
  assign bad_end = acc & s_last & ~(at_end & row_odd);
  // Both columns of a pair share one buffer entry.
  assign lb_addr = col[AW:1];

  always_comb begin
    lb_wr_en = 1'b0;
    lb_rd_en = 1'b0;
    load_win = 1'b0;
    if (acc) begin
      unique case (phase)
        PH_TOP_R: lb_wr_en = 1'b1;
        PH_BOT_L: lb_rd_en = 1'b1;
        PH_BOT_R: load_win = ~bad_end;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      col     <= '0;
      row_odd <= 1'b0;
    end else if (acc) begin
      if (s_last) begin
        col     <= '0;
        row_odd <= 1'b0;
      end else if (at_end) begin
        col     <= '0;
        row_odd <= ~row_odd;
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (acc && (phase == PH_TOP_L)) top_hold <= s_data;
    if (acc && (phase == PH_BOT_L)) bot_hold <= s_data;
  end

  pool_line_buf #(
    .data_width (data_width),
    .depth      (LB_DEPTH),
    .addr_w     (AW)
  ) u_line_buf (
    .aclk    (aclk),
    .aclken  (aclken),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data ({s_data, top_hold}),
    .rd_en   (lb_rd_en),
    .rd_addr (lb_addr),
    .rd_data (lb_rd_data)
  );

  // A load may coincide with the drain of the previous window; the load wins.
  always_ff @(posedge aclk) begin
    if (areset) begin
      win_vld   <= 1'b0;
      win_last  <= 1'b0;
      win_data  <= '0;
      frame_err <= 1'b0;
    end else if (aclken) begin
      frame_err <= bad_end;
      if (load_win) begin
        win_vld  <= 1'b1;
        win_last <= s_last;
        win_data[WIN_TL*data_width +: data_width] <= lb_rd_data[0 +: data_width];
        win_data[WIN_TR*data_width +: data_width] <= lb_rd_data[data_width +: data_width];
        win_data[WIN_BL*data_width +: data_width] <= bot_hold;
        win_data[WIN_BR*data_width +: data_width] <= s_data;
      end else if (win_ready) begin
        win_vld  <= 1'b0;
        win_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_win_buf.sv
module tb_max_pool_win_buf;
  localparam int DW = 8;
  localparam int MW = 64;
  localparam int CW = $clog2(MW + 1);

  logic          aclk = 1'b0;
  logic          areset, aclken, s_valid, s_last, s_ready;
  logic          win_vld, win_last, win_ready, frame_err;
  logic [CW-1:0] fmap_w;
  logic [DW-1:0] s_data;
  logic [4*DW-1:0] win_data;

  always #5 aclk = ~aclk;

  max_pool_win_buf #(.data_width(DW), .max_fmap_w(MW), .simulation_delay(1)) dut (
    .aclk(aclk), .areset(areset), .aclken(aclken), .fmap_w(fmap_w),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .win_data(win_data), .win_vld(win_vld), .win_last(win_last),
    .win_ready(win_ready), .frame_err(frame_err)
  );

  typedef struct packed { logic last; logic [4*DW-1:0] data; } win_t;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: pixel position within the frame ----
  logic            mdl_vld = 1'b0, mdl_last = 1'b0, mdl_err = 1'b0;
  logic [4*DW-1:0] mdl_data = '0, mnd;
  logic [DW-1:0]   pix [2][MW];
  int              k = 0, mw, mr, mc;
  bit              macc, mld, mer, mon_on = 0;
  win_t            got_q[$];
  int              err_rise = 0;
  logic            err_prev = 1'b0;
  bit              bp_rand = 0, en_rand = 0, bub_rand = 0;
  logic [DW-1:0]   frm [8*MW];

  initial forever begin
    @(negedge aclk);
    if (mon_on) begin
      chk("s_ready", s_ready, aclken & ~areset & (~mdl_vld | win_ready));
      chk("win_vld", win_vld, mdl_vld);
      chk("win_data", win_data, mdl_data);
      if (mdl_vld) chk("win_last", win_last, mdl_last);
      chk("frame_err", frame_err, mdl_err);
    end
    if (frame_err === 1'b1 && err_prev !== 1'b1) err_rise++;
    err_prev = frame_err;
    if (win_vld && win_ready && aclken && !areset) got_q.push_back({win_last, win_data});
    // next model state from the inputs present at the coming edge
    if (areset) begin
      mdl_vld = 0; mdl_last = 0; mdl_data = '0; mdl_err = 0; k = 0;
    end else if (aclken) begin
      mw   = int'(fmap_w) & ~1;
      macc = s_valid && (!mdl_vld || win_ready);
      mld  = 0;
      mer  = 0;
      if (macc) begin
        mr = k / mw;
        mc = k % mw;
        pix[mr % 2][mc] = s_data;
        if (s_last && !(mc == mw - 1 && mr % 2 == 1)) begin
          mer = 1;
          k   = 0;
        end else begin
          if (mr % 2 == 1 && mc % 2 == 1) begin
            mld = 1;
            mnd = {s_data, pix[1][mc-1], pix[0][mc], pix[0][mc-1]};
          end
          k = s_last ? 0 : k + 1;
        end
      end
      mdl_err = mer;
      if (mld) begin
        mdl_vld = 1; mdl_data = mnd; mdl_last = s_last;
      end else if (win_ready) begin
        mdl_vld = 0;
      end
    end
  end

  // random backpressure / enable, applied just after each edge
  initial forever begin
    @(posedge aclk); #1;
    if (bp_rand) win_ready = ($urandom_range(0, 3) != 0);
    if (en_rand) aclken = ($urandom_range(0, 4) != 0);
  end

  // ---------------- stimulus helpers -------------------------------------
  task automatic send_px(input logic [DW-1:0] d, input bit last);
    bit ok = 0;
    s_data = d; s_last = last; s_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge aclk); ok = s_ready;
      @(posedge aclk); #1;
    end
    chk("send_accept", ok, 1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input bit has_last, input int gate_at);
    logic [4*DW:0] hold;
    for (int i = 0; i < n; i++) begin
      if (bub_rand) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      send_px(frm[i], has_last && (i == n - 1));
      if (i == gate_at) begin
        s_data = frm[i+1]; s_last = 1'b0; s_valid = 1'b1;
        aclken = 1'b0;
        hold = {win_vld, win_data};
        repeat (3) begin
          @(negedge aclk);
          chk("gate_s_ready", s_ready, 0);
          chk("gate_hold", {win_vld, win_data}, hold);
          @(posedge aclk); #1;
        end
        aclken = 1'b1;
      end
    end
  endtask

  task automatic bp_watch();
    logic [4*DW-1:0] hold;
    for (int i = 0; i < 100 && !win_vld; i++) begin @(posedge aclk); #1; end
    chk("bp_win_seen", win_vld, 1);
    hold = win_data;
    win_ready = 1'b0;
    repeat (5) begin
      @(negedge aclk);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_data", win_data, hold);
      @(posedge aclk); #1;
    end
    win_ready = 1'b1;
  endtask

  task automatic start_frame();
    got_q.delete();
    err_rise = 0;
  endtask

  task automatic finish_frame();
    s_valid = 1'b0;
    en_rand = 0; aclken = 1'b1;
    repeat (2) begin @(posedge aclk); #1; end
    for (int i = 0; i < 200 && win_vld; i++) begin @(posedge aclk); #1; end
    chk("drain", win_vld, 0);
  endtask

  // Expected windows straight from the frame picture: every odd-row/odd-col
  // pixel closes a 2x2 block, unless it carried an off-grid s_last.
  task automatic check_windows(input int w, input int n, input bit has_last);
    win_t exp_q[$];
    bit legal;
    legal = has_last && (n % (2 * w) == 0);
    for (int b = 0; b < n; b++) begin
      if (((b / w) % 2 == 1) && ((b % w) % 2 == 1) && (b < n - 1 || legal || !has_last))
        exp_q.push_back({legal && (b == n - 1), frm[b], frm[b-1], frm[b-w], frm[b-w-1]});
    end
    chk("win_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("win%0d", i), got_q[i], exp_q[i]);
  endtask

  task automatic end_frame(input int w, input int n, input bit has_last);
    finish_frame();
    check_windows(w, n, has_last);
    chk("err_pulses", err_rise, (has_last && (n % (2 * w) != 0)) ? 1 : 0);
  endtask

  task automatic fill_ramp(input int n);
    for (int i = 0; i < n; i++) frm[i] = DW'(i);
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) frm[i] = DW'($urandom);
  endtask

  task automatic run_frame(input int w, input int n, input int gate_at);
    fmap_w = CW'(w);
    start_frame();
    drive_pixels(n, 1, gate_at);
    end_frame(w, n, 1);
  endtask

  int rw, rh, rn, mx;

  initial begin
    areset = 1'b1; aclken = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    win_ready = 1'b1; fmap_w = CW'(4);
    @(posedge aclk); #1;
    mon_on = 1;
    @(negedge aclk);
    chk("rst_win_vld", win_vld, 0);
    chk("rst_win_last", win_last, 0);
    chk("rst_win_data", win_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_s_ready", s_ready, 0);
    @(posedge aclk); #1;
    areset = 1'b0;

    // 4x4 ramp
    fill_ramp(16);
    run_frame(4, 16, -1);

    // signed 2x4 frame, reduced to a max per window
    frm[0] = 8'h80; frm[1] = 8'h7f; frm[2] = 8'hff; frm[3] = 8'h00;
    frm[4] = 8'h05; frm[5] = 8'hfb; frm[6] = 8'h64; frm[7] = 8'h9c;
    run_frame(4, 8, -1);
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      mx = -1000;
      for (int e = 0; e < 4; e++)
        if ($signed(got_q[i].data[e*DW +: DW]) > mx) mx = $signed(got_q[i].data[e*DW +: DW]);
      chk($sformatf("max%0d", i), mx, (i == 0) ? 127 : 100);
    end

    // backpressure after the first window
    fill_ramp(16);
    fmap_w = CW'(4);
    start_frame();
    fork
      drive_pixels(16, 1, -1);
      bp_watch();
    join
    end_frame(4, 16, 1);

    // enable dropped mid odd row, between the read issue and its use
    run_frame(4, 16, 12);

    // off-grid s_last on pixel 5, then a clean frame
    run_frame(4, 6, -1);
    run_frame(4, 16, -1);

    // reset mid-frame after pixel 6
    start_frame();
    drive_pixels(7, 0, -1);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_mid_vld", win_vld, 0);
    chk("rst_mid_err", frame_err, 0);
    @(posedge aclk); #1;
    end_frame(4, 7, 0);
    run_frame(4, 16, -1);

    // full width 64x2
    fill_rand(128);
    run_frame(64, 128, -1);

    // randomized frames with bubbles, backpressure, enable gaps, odd fmap_w
    for (int f = 0; f < 25; f++) begin
      rw = 2 * $urandom_range(1, 32);
      rh = 2 * $urandom_range(1, 3);
      rn = rw * rh;
      if ($urandom_range(0, 4) == 0) rn = $urandom_range(1, rn);
      fill_rand(rn);
      fmap_w = CW'(rw) | ((rw < MW) ? CW'($urandom_range(0, 1)) : CW'(0));
      start_frame();
      bub_rand = 1; bp_rand = 1; en_rand = 1;
      drive_pixels(rn, 1, -1);
      bp_rand = 0; win_ready = 1'b1;
      bub_rand = 0;
      end_frame(rw, rn, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
